// File: rtl/truss_run_controller.sv
// Run/shutdown sequencer for a truss test: collects component done flags,
// enforces global and inactivity timeouts, drains, then latches a verdict.
module truss_run_controller #(
   parameter int N_COMP       = 4,
   parameter int IDLE_LIMIT   = 1000,
   parameter int DRAIN_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [31:0]       timeout_limit,
   input  logic              abort,
   input  logic [N_COMP-1:0] done,
   input  logic [N_COMP-1:0] heartbeat,
   output logic              run,
   output logic              shutdown_req,
   output logic              test_done,
   output logic              pass,
   output logic              timeout_global,
   output logic              timeout_idle,
   output logic              aborted,
   output logic [N_COMP-1:0] done_seen,
   output logic [31:0]       cycle_count
);

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
   localparam logic [31:0]   IDLE_LIM   = 32'(IDLE_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [31:0]       r_limit;
   logic [31:0]       r_cnt;
   logic [31:0]       r_idle;
   logic [DW-1:0]     r_drain;
   logic [N_COMP-1:0] r_seen;
   logic              r_run;
   logic              r_shut;
   logic              r_tdone;
   logic              r_pass;
   logic              r_tg;
   logic              r_ti;
   logic              r_ab;

   logic [N_COMP-1:0] w_seen_now;
   logic              w_all;
   logic              w_hb;
   logic              w_glob;
   logic              w_idle_hit;
   logic              w_launch;
   logic              w_drain_end;
   logic              w_exit;
   logic              w_pass_n;
   logic              w_tg_n;
   logic              w_ti_n;
   logic              w_ab_n;

   assign w_seen_now  = r_seen | done;
   assign w_all       = &w_seen_now;
   assign w_hb        = |heartbeat;
   assign w_glob      = (r_limit != 32'd0) && (r_cnt + 32'd1 == r_limit);
   assign w_idle_hit  = (IDLE_LIMIT != 0) && !w_hb &&
                        (r_idle + 32'd1 == IDLE_LIM);
   assign w_launch    = start &&
                        ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_drain_end = (r_drain == DRAIN_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (w_exit) w_next = S_DRAIN;
         S_DRAIN: if (w_drain_end) w_next = S_DONE;
         S_DONE:  if (start) w_next = S_RUN;
         default: w_next = S_IDLE;
      endcase
   end

   // Exit causes in priority order; the first true one decides the verdict.
   always_comb begin
      w_exit   = 1'b0;
      w_pass_n = r_pass;
      w_tg_n   = r_tg;
      w_ti_n   = r_ti;
      w_ab_n   = r_ab;
      if (w_launch) begin
         w_pass_n = 1'b0;
         w_tg_n   = 1'b0;
         w_ti_n   = 1'b0;
         w_ab_n   = 1'b0;
      end else if (r_state == S_RUN) begin
         w_exit = 1'b1;
         priority case (1'b1)
            abort:      w_ab_n   = 1'b1;
            w_all:      w_pass_n = 1'b1;
            w_glob:     w_tg_n   = 1'b1;
            w_idle_hit: w_ti_n   = 1'b1;
            default:    w_exit   = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_limit <= '0;
         r_cnt   <= '0;
         r_idle  <= '0;
         r_drain <= '0;
         r_seen  <= '0;
         r_run   <= 1'b0;
         r_shut  <= 1'b0;
         r_tdone <= 1'b0;
         r_pass  <= 1'b0;
         r_tg    <= 1'b0;
         r_ti    <= 1'b0;
         r_ab    <= 1'b0;
      end else begin
         r_run   <= (w_next == S_RUN);
         r_shut  <= (w_next == S_DRAIN);
         r_tdone <= (w_next == S_DONE);
         r_pass  <= w_pass_n;
         r_tg    <= w_tg_n;
         r_ti    <= w_ti_n;
         r_ab    <= w_ab_n;
         if (w_launch) begin
            r_limit <= timeout_limit;
            r_cnt   <= '0;
            r_idle  <= '0;
            r_seen  <= '0;
         end else if (r_state == S_RUN) begin
            if (r_cnt != '1) r_cnt <= r_cnt + 32'd1;
            r_seen <= w_seen_now;
            if (w_hb)              r_idle <= '0;
            else if (r_idle != '1) r_idle <= r_idle + 32'd1;
         end else if (r_state == S_DRAIN) begin
            r_seen <= w_seen_now;
         end
         if ((r_state == S_DRAIN) && !w_drain_end)
            r_drain <= r_drain + DW'(1);
         else
            r_drain <= '0;
      end
   end

   assign run            = r_run;
   assign shutdown_req   = r_shut;
   assign test_done      = r_tdone;
   assign pass           = r_pass;
   assign timeout_global = r_tg;
   assign timeout_idle   = r_ti;
   assign aborted        = r_ab;
   assign done_seen      = r_seen;
   assign cycle_count    = r_cnt;

endmodule

// File: tb/tb_truss_run_controller.sv
// Bench for truss_run_controller: directed scenarios plus random traffic,
// every cycle compared against a phase/counter model of the run rules.
module tb_truss_run_controller;

   localparam int N     = 4;
   localparam int IDLE  = 8;
   localparam int DRAIN = 16;
   localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [31:0]   timeout_limit = '0;
   logic          abort = 1'b0;
   logic [N-1:0]  done = '0;
   logic [N-1:0]  heartbeat = '0;
   logic          run, shutdown_req, test_done, pass;
   logic          timeout_global, timeout_idle, aborted;
   logic [N-1:0]  done_seen;
   logic [31:0]   cycle_count;

   int checks = 0;
   int errors = 0;

   int           m_ph = P_IDLE;
   longint       m_cnt = 0;
   longint       m_lim = 0;
   int           m_idle = 0;
   int           m_dleft = 0;
   int           m_cause = 0;
   logic [N-1:0] m_seen = '0;
   logic [N-1:0] m_now = '0;
   bit           m_pass = 0, m_tg = 0, m_ti = 0, m_ab = 0;

   truss_run_controller #(
      .N_COMP(N), .IDLE_LIMIT(IDLE), .DRAIN_CYCLES(DRAIN)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .timeout_limit(timeout_limit), .abort(abort),
      .done(done), .heartbeat(heartbeat), .run(run),
      .shutdown_req(shutdown_req), .test_done(test_done),
      .pass(pass), .timeout_global(timeout_global),
      .timeout_idle(timeout_idle), .aborted(aborted),
      .done_seen(done_seen), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] a,
                      input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
      end
   endtask

   // Reference model: phases and counters straight from the run rules.
   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         m_ph = P_IDLE; m_cnt = 0; m_lim = 0; m_idle = 0; m_dleft = 0;
         m_seen = '0; m_pass = 0; m_tg = 0; m_ti = 0; m_ab = 0;
      end else if (m_ph == P_IDLE || m_ph == P_DONE) begin
         if (start) begin
            m_ph = P_RUN; m_lim = longint'(timeout_limit);
            m_cnt = 0; m_idle = 0; m_seen = '0;
            m_pass = 0; m_tg = 0; m_ti = 0; m_ab = 0;
         end
      end else if (m_ph == P_RUN) begin
         m_now = m_seen | done;
         if (abort) m_cause = 1;
         else if (m_now == '1) m_cause = 2;
         else if (m_lim != 0 && m_cnt + 1 == m_lim) m_cause = 3;
         else if (heartbeat == '0 && m_idle + 1 == IDLE) m_cause = 4;
         else m_cause = 0;
         if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
         m_seen = m_now;
         m_idle = (heartbeat != '0) ? 0 : m_idle + 1;
         if (m_cause != 0) begin
            m_ab = (m_cause == 1); m_pass = (m_cause == 2);
            m_tg = (m_cause == 3); m_ti = (m_cause == 4);
            m_ph = P_DRAIN; m_dleft = DRAIN;
         end
      end else begin
         m_seen = m_seen | done;
         m_dleft = m_dleft - 1;
         if (m_dleft == 0) m_ph = P_DONE;
      end
   end

   initial forever begin
      @(negedge clk);
      chk("run", 64'(run), 64'(m_ph == P_RUN));
      chk("shutdown_req", 64'(shutdown_req), 64'(m_ph == P_DRAIN));
      chk("test_done", 64'(test_done), 64'(m_ph == P_DONE));
      chk("pass", 64'(pass), 64'(m_pass));
      chk("timeout_global", 64'(timeout_global), 64'(m_tg));
      chk("timeout_idle", 64'(timeout_idle), 64'(m_ti));
      chk("aborted", 64'(aborted), 64'(m_ab));
      chk("done_seen", 64'(done_seen), 64'(m_seen));
      chk("cycle_count", 64'(cycle_count), 64'(m_cnt));
      if (m_ph == P_DONE)
         chk("one_cause", 64'(pass + timeout_global + timeout_idle
                              + aborted), 64'(1));
   end

   task automatic chk_zero(input string nm);
      chk({nm, "_run"}, 64'(run), 64'(0));
      chk({nm, "_shut"}, 64'(shutdown_req), 64'(0));
      chk({nm, "_tdone"}, 64'(test_done), 64'(0));
      chk({nm, "_flags"}, 64'({pass, timeout_global, timeout_idle,
                               aborted}), 64'(0));
      chk({nm, "_seen"}, 64'(done_seen), 64'(0));
      chk({nm, "_cnt"}, 64'(cycle_count), 64'(0));
   endtask

   task automatic reset_pulse();
      #2 reset_n = 1'b0;
      #1 chk_zero("async_reset");
      start = 0; abort = 0; done = '0; heartbeat = '0;
      @(negedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
   endtask

   // Start a run from IDLE/DONE and drive per-RUN-cycle stimulus until DONE.
   task automatic drive_run(input int mode, input int lim,
                            output int n_run, output int n_drain);
      int k;
      bit ok;
      k = 0; n_run = 0; n_drain = 0; ok = 0;
      start = 1; timeout_limit = 32'(lim);
      abort = 0; done = '0; heartbeat = '0;
      for (int it = 0; it < 400; it++) begin
         @(negedge clk);
         start = 0; abort = 0; done = '0; heartbeat = '0;
         if (it == 0) begin
            chk("launch_run", 64'(run), 64'(1));
            chk("launch_clear", 64'({done_seen, pass, timeout_global,
                                     timeout_idle, aborted}), 64'(0));
            chk("launch_cnt", 64'(cycle_count), 64'(0));
         end
         if (run) n_run++;
         if (shutdown_req) n_drain++;
         if (test_done) begin
            ok = 1;
            break;
         end
         k++;
         case (mode)
            0, 6: begin
               if (k == 5)  done = 4'b0001;
               if (k == 9)  done = 4'b0010;
               if (k == 12) done = 4'b0100;
               if (k == 20) done = 4'b1000;
               heartbeat = (k % 3 == 0) ? 4'hF : 4'h0;
               if (mode == 6 && (k == 7 || k == 25)) start = 1;
            end
            1: begin
               done = 4'b0111; heartbeat = 4'hF;
            end
            2: heartbeat = (k == 2) ? 4'b0001 : 4'b0000;
            3: begin
               heartbeat = (k == 2 || k == 10) ? 4'b0010 : 4'b0000;
               abort = (k == 14);
            end
            default: begin
               done = (k < 10) ? 4'b0111 : 4'b1000;
               heartbeat = 4'hF;
               abort = (mode == 5 && k == 10);
            end
         endcase
      end
      if (!ok) chk("run_bound", 64'(0), 64'(1));
      start = 0; abort = 0; done = '0; heartbeat = '0;
   endtask

   initial begin
      int nr, nd;
      @(negedge clk);
      chk_zero("reset");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      drive_run(0, 100, nr, nd);
      chk("clean_run_len", 64'(nr), 64'(20));
      chk("clean_drain_len", 64'(nd), 64'(16));
      chk("clean_pass", 64'(pass), 64'(1));
      chk("clean_cnt", 64'(cycle_count), 64'(20));
      chk("clean_seen", 64'(done_seen), 64'(4'hF));

      drive_run(1, 50, nr, nd);
      chk("glob_run_len", 64'(nr), 64'(50));
      chk("glob_cnt", 64'(cycle_count), 64'(50));
      chk("glob_flags", 64'({pass, timeout_global}), 64'(2'b01));

      drive_run(2, 0, nr, nd);
      chk("idle_run_len", 64'(nr), 64'(10));
      chk("idle_flag", 64'(timeout_idle), 64'(1));

      drive_run(3, 0, nr, nd);
      chk("idle_saved_len", 64'(nr), 64'(14));
      chk("idle_saved_flags", 64'({timeout_idle, aborted}), 64'(2'b01));

      drive_run(4, 10, nr, nd);
      chk("coll_len", 64'(nr), 64'(10));
      chk("coll_flags", 64'({pass, timeout_global}), 64'(2'b10));

      drive_run(5, 10, nr, nd);
      chk("coll_abort", 64'({pass, timeout_global, aborted}), 64'(3'b001));

      drive_run(6, 100, nr, nd);
      chk("ign_start_len", 64'(nr), 64'(20));
      chk("ign_start_drain", 64'(nd), 64'(16));
      chk("ign_start_pass", 64'(pass), 64'(1));

      drive_run(0, 100, nr, nd);
      chk("restart_len", 64'(nr), 64'(20));

      @(negedge clk);
      start = 1; timeout_limit = 0; heartbeat = 4'hF;
      @(negedge clk);
      start = 0;
      repeat (5) @(negedge clk);
      chk("mid_run", 64'(run), 64'(1));
      reset_pulse();
      chk("after_reset_idle", 64'(run), 64'(0));
      drive_run(0, 100, nr, nd);
      chk("post_reset_len", 64'(nr), 64'(20));

      @(negedge clk);
      start = 1; timeout_limit = 0;
      @(negedge clk);
      start = 0; abort = 1;
      @(negedge clk);
      abort = 0;
      repeat (3) @(negedge clk);
      chk("mid_drain", 64'(shutdown_req), 64'(1));
      reset_pulse();
      drive_run(1, 50, nr, nd);
      chk("post_reset2_len", 64'(nr), 64'(50));

      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         start = ($urandom_range(0, 15) == 0);
         timeout_limit = 32'($urandom_range(0, 40));
         abort = ($urandom_range(0, 63) == 0);
         done = N'($urandom) & N'($urandom) & N'($urandom);
         heartbeat = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         if ($urandom_range(0, 399) == 0) reset_pulse();
      end
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
